// File: rtl/boundary_scan_register.sv
// Boundary-scan data register: WIDTH capture/shift/update cells chained TDI -> cell[WIDTH-1] -> cell[0] -> TDO.
// Strobes are single-TCK synchronous enables from the TAP controller. Pins are muxed between functional and update values.
module boundary_scan_register #(
  parameter int unsigned              WIDTH      = 8,
  parameter logic [WIDTH-1:0]         SAFE_VALUE = {WIDTH{1'b0}},
  parameter int unsigned              CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             TCK,
  input  logic             TRST_n,
  input  logic             TDI,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  logic             Mode,
  input  logic [WIDTH-1:0] sys_pin,
  output logic [WIDTH-1:0] module_pin,
  output logic             TDO,
  output logic [CNT_W-1:0] shift_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Capture outranks shift, so a held CaptureDR freezes the chain on sys_pin.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (CaptureDR) begin
      shift_d = sys_pin;
      cnt_d   = '0;
    end else if (ShiftDR) begin
      shift_d = {TDI, shift_q[WIDTH-1:1]};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Update latches the word as it stood before this edge's capture/shift.
  always_comb begin
    upd_d = upd_q;
    if (UpdateDR) begin
      upd_d = shift_q;
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      shift_q <= '0;
      upd_q   <= SAFE_VALUE;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign module_pin = Mode ? upd_q : sys_pin;
  assign TDO        = shift_q[0];
  assign shift_cnt  = cnt_q;

endmodule

// File: tb/tb_boundary_scan_register.sv
// Bench for boundary_scan_register (WIDTH=4, SAFE_VALUE=4'b1010): directed vectors plus a short model-checked random run.
module tb_boundary_scan_register;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int EW   = 1 + CW + W;
  localparam logic [W-1:0] SAFE = 4'b1010;

  logic          TCK = 1'b0;
  logic          TRST_n;
  logic          TDI, CaptureDR, ShiftDR, UpdateDR, Mode;
  logic [W-1:0]  sys_pin, module_pin;
  logic          TDO;
  logic [CW-1:0] shift_cnt;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // Clock / reset
  always #5 TCK = ~TCK;

  boundary_scan_register #(.WIDTH(W), .SAFE_VALUE(SAFE), .CNT_W(CW)) dut (
    .TCK(TCK), .TRST_n(TRST_n), .TDI(TDI), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
    .UpdateDR(UpdateDR), .Mode(Mode), .sys_pin(sys_pin), .module_pin(module_pin),
    .TDO(TDO), .shift_cnt(shift_cnt)
  );

  function automatic logic [EW-1:0] pk(input logic t, input logic [CW-1:0] c, input logic [W-1:0] p);
    return {t, c, p};
  endfunction

  // Driver: applies inputs 2 time units after a rising edge, queues the outputs expected
  // before the next rising edge, then advances one TCK.
  task automatic cyc(input logic rst, input logic cap, input logic sh, input logic upd,
                     input logic tdi, input logic mode, input logic [W-1:0] sys,
                     input logic [EW-1:0] exp, input string nm);
    TRST_n = rst; CaptureDR = cap; ShiftDR = sh; UpdateDR = upd;
    TDI = tdi; Mode = mode; sys_pin = sys;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge TCK);
    #2;
  endtask

  // Monitor: outputs are stable at the falling edge, between driver updates and the next rising edge.
  always @(negedge TCK) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {TDO, shift_cnt, module_pin};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got tdo=%b cnt=%0d pin=%b, expected tdo=%b cnt=%0d pin=%b",
                    nm, g[EW-1], g[EW-2 -: CW], g[W-1:0], e[EW-1], e[EW-2 -: CW], e[W-1:0]);
    end
  end

  logic [W-1:0]  m_shift, m_upd;
  logic [CW-1:0] m_cnt;

  initial begin
    TRST_n = 1'b0; TDI = 0; CaptureDR = 0; ShiftDR = 0; UpdateDR = 0; Mode = 1; sys_pin = '0;
    @(posedge TCK);
    #2;

    // Reset values and the pass-through mux
    cyc(0,0,0,0,0, 1, 4'b0000, pk(0,0,4'b1010), "reset_mode1");
    cyc(0,0,0,0,0, 0, 4'b0110, pk(0,0,4'b0110), "reset_mode0");

    // Capture 1101 then shift out with TDI=0; 5th shift saturates the count
    cyc(1,1,0,0,0, 0, 4'b1101, pk(0,0,4'b1101), "pre_capture");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(1,0,4'b1101), "shift_tdo0");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(0,1,4'b1101), "shift_tdo1");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(1,2,4'b1101), "shift_tdo2");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(1,3,4'b1101), "shift_tdo3");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(0,4,4'b1101), "shift_full");
    cyc(1,0,0,0,0, 0, 4'b1101, pk(0,4,4'b1101), "shift_saturate");

    // Shift in 0011 (TDI 1,1,0,0), update, observe in test mode
    cyc(1,0,1,0,1, 0, 4'b1101, pk(0,4,4'b1101), "shin_a");
    cyc(1,0,1,0,1, 0, 4'b1101, pk(0,4,4'b1101), "shin_b");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(0,4,4'b1101), "shin_c");
    cyc(1,0,1,0,0, 0, 4'b1101, pk(0,4,4'b1101), "shin_d");
    cyc(1,0,0,1,0, 1, 4'b1101, pk(1,4,4'b1010), "pre_update_safe");
    cyc(1,0,0,0,0, 1, 4'b1101, pk(1,4,4'b0011), "update_to_pin");
    cyc(1,0,0,0,0, 0, 4'b0101, pk(1,4,4'b0101), "mode0_passthru");
    cyc(1,0,0,0,0, 1, 4'b0101, pk(1,4,4'b0011), "upd_unchanged");

    // Same-edge strobes
    cyc(1,1,1,0,1, 1, 4'b1001, pk(1,4,4'b0011), "cap_shift_pre");
    cyc(1,0,1,1,0, 1, 4'b1001, pk(1,0,4'b0011), "capture_wins");
    cyc(1,0,0,0,0, 1, 4'b1001, pk(0,1,4'b1001), "update_preshift");

    // Asynchronous reset after 2 of 4 shifts, then release with ShiftDR held
    cyc(1,1,0,0,0, 1, 4'b1111, pk(0,1,4'b1001), "cap_1111");
    cyc(1,0,1,0,0, 1, 4'b1111, pk(1,0,4'b1001), "mid_shift1");
    cyc(1,0,1,0,0, 1, 4'b1111, pk(1,1,4'b1001), "mid_shift2");
    cyc(0,0,1,0,0, 1, 4'b1111, pk(0,0,4'b1010), "async_reset");
    cyc(1,0,1,0,1, 1, 4'b1111, pk(0,0,4'b1010), "hold_until_edge");
    cyc(1,0,0,0,0, 1, 4'b1111, pk(0,1,4'b1010), "first_edge_after");

    // Random run against a reference model (state after the last directed cycle)
    m_shift = 4'b1000; m_upd = SAFE; m_cnt = 3'd1;
    for (int i = 0; i < 60; i++) begin
      logic c, s, u, t, m;
      logic [W-1:0] sp, ep;
      c  = ($urandom_range(0, 4) == 0);
      s  = ($urandom_range(0, 2) != 0);
      u  = ($urandom_range(0, 3) == 0);
      t  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      sp = W'($urandom_range(0, 15));
      ep = m ? m_upd : sp;
      cyc(1, c, s, u, t, m, sp, pk(m_shift[0], m_cnt, ep), "random");
      if (u) m_upd = m_shift;
      if (c) begin
        m_shift = sp; m_cnt = '0;
      end else if (s) begin
        m_shift = {t, m_shift[W-1:1]};
        if (m_cnt < CW'(W)) m_cnt = m_cnt + 1'b1;
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge TCK);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
      n_checks += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
